// File: rtl/overdrive_pkg.sv
// rtl/overdrive_pkg.sv - shared types, limits and saturation helper for the overdrive scheduler
package overdrive_pkg;

  typedef logic signed [31:0] sample_t;

  localparam sample_t SAMPLE_MAX = 32'sh7FFF_FFFF;
  localparam sample_t SAMPLE_MIN = 32'sh8000_0000;

  // Tag channel field is sized for the largest supported channel count.
  localparam int MAX_CH = 16;
  localparam int CH_W   = $clog2(MAX_CH);
  localparam int WIDE_W = 48;

  typedef logic signed [WIDE_W-1:0] wide_t;

  typedef struct packed {
    logic            valid;
    logic [CH_W-1:0] ch;
    logic            bypass;
    sample_t         raw;
  } tag_t;

  function automatic sample_t sat32(input wide_t v);
    if (v > WIDE_W'(SAMPLE_MAX)) begin
      return SAMPLE_MAX;
    end else if (v < WIDE_W'(SAMPLE_MIN)) begin
      return SAMPLE_MIN;
    end
    return v[31:0];
  endfunction

endpackage

// File: rtl/overdrive_scheduler_if.sv
// rtl/overdrive_scheduler_if.sv - per-channel sample request bundle feeding the scheduler
interface overdrive_scheduler_if
  import overdrive_pkg::*;
#(
  parameter int N_CH = 4
);

  logic    [N_CH-1:0] in_valid;
  logic    [N_CH-1:0] in_ready;
  sample_t [N_CH-1:0] in_sample;

  modport master (output in_valid, output in_sample, input in_ready);
  modport slave  (input in_valid, input in_sample, output in_ready);

endinterface

// File: rtl/overdrive_rr_arbiter.sv
// rtl/overdrive_rr_arbiter.sv - round-robin grant of the first requester after the pointer
module overdrive_rr_arbiter #(
  parameter int N_CH = 4
) (
  input  logic [N_CH-1:0]         req,
  input  logic [$clog2(N_CH)-1:0] ptr,
  output logic [N_CH-1:0]         grant,
  output logic [$clog2(N_CH)-1:0] grant_idx,
  output logic                    any_grant
);

  localparam int IW = $clog2(N_CH);

  int c;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    c         = 0;
    for (int k = 1; k <= N_CH; k++) begin
      c = (int'(ptr) + k) % N_CH;
      if (!any_grant && req[c]) begin
        grant[c]  = 1'b1;
        grant_idx = c[IW-1:0];
        any_grant = 1'b1;
      end
    end
  end

endmodule

// File: rtl/overdrive_scheduler.sv
// rtl/overdrive_scheduler.sv - time-shares one clip datapath between N_CH channels with tagged results
module overdrive_scheduler
  import overdrive_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int CLIP_LAT = 2,
  parameter int SHIFT_W  = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enable,
  overdrive_scheduler_if.slave           ifc,
  input  logic [N_CH-1:0][SHIFT_W-1:0]   cfg_drive_shift,
  input  logic [N_CH-1:0]                cfg_bypass,
  output sample_t                        clip_x,
  output logic                           clip_x_valid,
  input  sample_t                        clip_y,
  output logic                           out_valid,
  output logic [$clog2(N_CH)-1:0]        out_ch,
  output sample_t                        out_sample,
  output logic                           busy
);

  localparam int IW = $clog2(N_CH);

  logic [N_CH-1:0]    req;
  logic [N_CH-1:0]    grant;
  logic [IW-1:0]      grant_idx;
  logic               transfer;
  logic [IW-1:0]      ptr;
  sample_t            sel_raw;
  logic [SHIFT_W-1:0] sel_shift;
  logic               sel_byp;
  wide_t              wide;
  sample_t            issue_val;
  tag_t               pipe [CLIP_LAT+1];

  // Reset also masks requests so in_ready reads zero while held in reset.
  assign req          = (enable && !rst) ? ifc.in_valid : '0;
  assign ifc.in_ready = grant;

  overdrive_rr_arbiter #(.N_CH(N_CH)) u_arb (
    .req       (req),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (transfer)
  );

  // Shift in a wide signed domain so overflow is visible before clamping.
  always_comb begin
    sel_raw   = ifc.in_sample[grant_idx];
    sel_shift = cfg_drive_shift[grant_idx];
    sel_byp   = cfg_bypass[grant_idx];
    wide      = WIDE_W'(sel_raw) <<< sel_shift;
    issue_val = sel_byp ? sel_raw : sat32(wide);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr          <= IW'(N_CH - 1);
      clip_x       <= '0;
      clip_x_valid <= 1'b0;
    end else begin
      clip_x_valid <= transfer;
      if (transfer) begin
        ptr    <= grant_idx;
        clip_x <= issue_val;
      end
    end
  end

  // Tags march in lockstep with the datapath; no stall exists downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= CLIP_LAT; i++) begin
        pipe[i] <= '0;
      end
    end else begin
      pipe[0] <= '{valid: transfer, ch: CH_W'(grant_idx), bypass: sel_byp, raw: sel_raw};
      for (int i = 1; i <= CLIP_LAT; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_ch     <= '0;
      out_sample <= '0;
    end else begin
      out_valid <= pipe[CLIP_LAT].valid;
      if (pipe[CLIP_LAT].valid) begin
        out_ch     <= IW'(pipe[CLIP_LAT].ch);
        out_sample <= pipe[CLIP_LAT].bypass ? pipe[CLIP_LAT].raw : clip_y;
      end
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i <= CLIP_LAT; i++) begin
      busy = busy | pipe[i].valid;
    end
  end

endmodule

// File: tb/tb_overdrive_scheduler.sv
// tb/tb_overdrive_scheduler.sv - directed self-checking bench for overdrive_scheduler
module tb_overdrive_scheduler;
  import overdrive_pkg::*;

  localparam int N_CH     = 4;
  localparam int CLIP_LAT = 2;
  localparam int SHIFT_W  = 3;

  logic                         clk = 1'b0;
  logic                         rst;
  logic                         enable;
  logic [N_CH-1:0][SHIFT_W-1:0] cfg_drive_shift;
  logic [N_CH-1:0]              cfg_bypass;
  sample_t                      clip_x;
  logic                         clip_x_valid;
  sample_t                      clip_y;
  logic                         out_valid;
  logic [1:0]                   out_ch;
  sample_t                      out_sample;
  logic                         busy;

  int n_checks = 0;
  int n_errors = 0;

  sample_t d1 = '0;
  sample_t d2 = '0;

  sample_t     t4_in  [4];
  logic [31:0] t4_exp [4];

  overdrive_scheduler_if #(.N_CH(N_CH)) ifc ();

  overdrive_scheduler #(
    .N_CH     (N_CH),
    .CLIP_LAT (CLIP_LAT),
    .SHIFT_W  (SHIFT_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .enable          (enable),
    .ifc             (ifc.slave),
    .cfg_drive_shift (cfg_drive_shift),
    .cfg_bypass      (cfg_bypass),
    .clip_x          (clip_x),
    .clip_x_valid    (clip_x_valid),
    .clip_y          (clip_y),
    .out_valid       (out_valid),
    .out_ch          (out_ch),
    .out_sample      (out_sample),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  // Cubic soft clip y = (3x - x^3)/2 in Q1.31, two-stage pipe
  function automatic sample_t cubic_clip(input sample_t x);
    longint xv;
    longint t;
    longint y;
    xv = longint'(x);
    t  = (xv * xv) >>> 31;
    t  = (t * xv) >>> 31;
    y  = (3 * xv - t) >>> 1;
    if (y > 64'sd2147483647) y = 64'sd2147483647;
    if (y < -64'sd2147483648) y = -64'sd2147483648;
    return sample_t'(y);
  endfunction

  always @(posedge clk) begin
    d1 <= cubic_clip(clip_x);
    d2 <= d1;
  end
  assign clip_y = d2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    enable       = 1'b0;
    ifc.in_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst             = 1'b1;
    enable          = 1'b1;
    ifc.in_valid    = 4'b1111;
    ifc.in_sample   = '0;
    cfg_drive_shift = '0;
    cfg_bypass      = '0;
    t4_in  = '{32'sh4000_0000, 32'shC000_0000, 32'sh1FFF_FFFF, 32'shE000_0001};
    t4_exp = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFC, 32'h8000_0004};

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_clip_x_valid", clip_x_valid, 0);
    check("rst_clip_x", clip_x, 0);
    check("rst_out_sample", out_sample, 0);
    check("rst_out_ch", out_ch, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", ifc.in_ready, 0);

    // 1: single sample on ch0
    ifc.in_valid     = 4'b0001;
    ifc.in_sample[0] = 1000;
    rst              = 1'b0;
    #1;
    check("t1_ready", ifc.in_ready, 4'b0001);
    step();
    ifc.in_valid = '0;
    check("t1_clip_x", clip_x, 1000);
    check("t1_clip_x_valid", clip_x_valid, 1);
    check("t1_busy", busy, 1);
    check("t1_out_early0", out_valid, 0);
    step();
    check("t1_clip_x_valid_off", clip_x_valid, 0);
    check("t1_out_early1", out_valid, 0);
    step();
    check("t1_out_early2", out_valid, 0);
    step();
    check("t1_out_valid", out_valid, 1);
    check("t1_out_ch", out_ch, 0);
    check("t1_out_sample", out_sample, 1500);
    check("t1_busy_done", busy, 0);
    step();
    check("t1_out_once", out_valid, 0);

    // 2: all channels streaming
    do_reset();
    enable = 1'b1;
    for (int c = 0; c < N_CH; c++) ifc.in_sample[c] = (c + 1) * 1000;
    for (int k = 0; k < 11; k++) begin
      ifc.in_valid = (k < 8) ? 4'b1111 : 4'b0000;
      #1;
      if (k < 8) check("t2_ready", ifc.in_ready, 32'(1 << (k % 4)));
      step();
      if (k < 8) check("t2_clip_x", clip_x, ((k % 4) + 1) * 1000);
      if (k >= 3) begin
        check("t2_out_valid", out_valid, 1);
        check("t2_out_ch", out_ch, (k - 3) % 4);
        check("t2_out_sample", out_sample, 1500 * (((k - 3) % 4) + 1));
      end
    end
    step();
    check("t2_out_idle", out_valid, 0);

    // 3: bypass ignores shift and clip result
    cfg_bypass[2]      = 1'b1;
    cfg_drive_shift[2] = 3'd3;
    ifc.in_sample[2]   = -12345;
    ifc.in_valid       = 4'b0100;
    #1;
    check("t3_ready", ifc.in_ready, 4'b0100);
    step();
    ifc.in_valid  = '0;
    cfg_bypass[2] = 1'b0;
    check("t3_clip_x", clip_x, -12345);
    repeat (3) step();
    check("t3_out_valid", out_valid, 1);
    check("t3_out_ch", out_ch, 2);
    check("t3_out_sample", out_sample, -12345);

    // 4: saturating drive shift
    cfg_drive_shift[1] = 3'd2;
    for (int k = 0; k < 4; k++) begin
      ifc.in_sample[1] = t4_in[k];
      ifc.in_valid     = 4'b0010;
      step();
      check("t4_clip_x", clip_x, t4_exp[k]);
    end
    ifc.in_valid = '0;
    repeat (4) step();
    cfg_drive_shift[1] = '0;

    // 5: reset with two samples in flight
    ifc.in_sample[0] = 111;
    ifc.in_sample[1] = 222;
    ifc.in_valid     = 4'b0011;
    step();
    check("t5_clip_x0", clip_x, 111);
    step();
    check("t5_clip_x1", clip_x, 222);
    ifc.in_valid = '0;
    check("t5_busy_pre", busy, 1);
    rst = 1'b1;
    #1;
    check("t5_rst_out_valid", out_valid, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_clip_x_valid", clip_x_valid, 0);
    step();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      check("t5_stale", out_valid, 0);
    end
    ifc.in_valid = 4'b1111;
    #1;
    check("t5_ready_ch0", ifc.in_ready, 4'b0001);
    step();
    ifc.in_valid = '0;
    check("t5_clip_x", clip_x, 111);
    repeat (3) step();
    check("t5_out_valid", out_valid, 1);
    check("t5_out_ch", out_ch, 0);
    check("t5_out_sample", out_sample, 166);
    step();

    // 6: enable drop drains, then resumes after the last grant
    ifc.in_sample[1] = 500;
    ifc.in_sample[3] = 700;
    ifc.in_valid     = 4'b0010;
    step();
    enable       = 1'b0;
    ifc.in_valid = 4'b1010;
    #1;
    check("t6_ready_off", ifc.in_ready, 0);
    check("t6_busy0", busy, 1);
    step();
    check("t6_busy1", busy, 1);
    check("t6_no_issue", clip_x_valid, 0);
    step();
    check("t6_busy2", busy, 1);
    step();
    check("t6_busy3", busy, 0);
    check("t6_out_valid", out_valid, 1);
    check("t6_out_ch", out_ch, 1);
    check("t6_out_sample", out_sample, 750);
    enable = 1'b1;
    #1;
    check("t6_ready_ch3", ifc.in_ready, 4'b1000);
    step();
    ifc.in_valid = '0;
    check("t6_clip_x", clip_x, 700);
    check("t6_clip_x_valid", clip_x_valid, 1);
    repeat (3) step();
    check("t6_out_ch3", out_ch, 3);
    check("t6_out_sample3", out_sample, 1050);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
